cache_controller: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache controller between the CPU datapath and `DataMemory`. It is the initiator of the memory's block-read/word-write protocol. On a read miss it holds `MemRead` with a line-aligned address for a fixed latency, then captures the 4-word `ReadData` block into a line. Writes are forwarded one word at a time, and the CPU is stalled via `cpu_ready` until each access completes.

---
 rtl/cache_controller.sv | 153 +++++++++++++++
 tb/tb_cache_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between the CPU and a block-read memory.
// Optional CACHE_STATS_EN adds saturating 16-bit hit_count / miss_count ports.
module cache_controller #(
    parameter int WORD_LEN    = 32,
    parameter int ADDRESS_LEN = 32,
    parameter int LINES       = 64,
    parameter int MEM_LAT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_LEN-1:0]  cpu_addr,
    input  logic [WORD_LEN-1:0]     cpu_wdata,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    output logic [WORD_LEN-1:0]     cpu_rdata,
    output logic                    cpu_ready,
    output logic [ADDRESS_LEN-1:0]  mem_addr,
    output logic [WORD_LEN-1:0]     mem_wdata,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [4*WORD_LEN-1:0]   mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
`endif
);
    localparam int IDX = $clog2(LINES);
    localparam int TW  = ADDRESS_LEN - 2 - IDX;
    localparam int CW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [TW-1:0]          tag_mem  [LINES];
    logic [WORD_LEN-1:0]    data_mem [LINES][4];
    logic [ADDRESS_LEN-3:0] fill_blk;
    logic [CW-1:0]          cnt;
    logic                   filled;

    logic [1:0]     off;
    logic [IDX-1:0] idx, fill_idx;
    logic [TW-1:0]  tag, fill_tag;
    logic           hit, rd_hit, fill_done;

    assign off       = cpu_addr[1:0];
    assign idx       = cpu_addr[2 +: IDX];
    assign tag       = cpu_addr[ADDRESS_LEN-1 -: TW];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    assign rd_hit    = (state == IDLE) && cpu_read && !cpu_write && hit;
    assign fill_idx  = fill_blk[IDX-1:0];
    assign fill_tag  = fill_blk[ADDRESS_LEN-3 -: TW];
    assign fill_done = (state == FILL) && (cnt == '0);

    // The block address is latched so a request dropped mid-fill still fills the right line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            valid    <= '0;
            cnt      <= '0;
            filled   <= 1'b0;
            fill_blk <= '0;
        end else begin
            case (state)
                IDLE: begin
                    filled <= 1'b0;
                    if (cpu_write) begin
                        state <= WRITE;
                    end else if (cpu_read && !hit) begin
                        state    <= FILL;
                        cnt      <= CW'(MEM_LAT - 1);
                        fill_blk <= cpu_addr[ADDRESS_LEN-1:2];
                    end
                end
                FILL: begin
                    if (cnt == '0) begin
                        valid[fill_idx] <= 1'b1;
                        filled          <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tags and data are never cleared; only valid bits gate their use.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (fill_done) begin
                tag_mem[fill_idx] <= fill_tag;
                for (int k = 0; k < 4; k++)
                    data_mem[fill_idx][k] <= mem_rdata[k*WORD_LEN +: WORD_LEN];
            end else if (state == WRITE && hit) begin
                data_mem[idx][off] <= cpu_wdata;
            end
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (!rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else begin
            case (state)
                IDLE: if (rd_hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_mem[idx][off];
                end
                FILL: begin
                    mem_read = 1'b1;
                    mem_addr = {fill_blk, 2'b00};
                end
                WRITE: begin
                    mem_write = 1'b1;
                    cpu_ready = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_q, miss_q;

    // The replay hit right after a fill belongs to the miss, not to the hit count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (rd_hit && !filled && hit_q != 16'hFFFF)
                hit_q <= hit_q + 16'd1;
            if (state == IDLE && cpu_read && !cpu_write && !hit && miss_q != 16'hFFFF)
                miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_count  = rst ? hit_q  : 16'd0;
    assign miss_count = rst ? miss_q : 16'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a 1K-word block-read memory model.
// Stats checks are compiled only when CACHE_STATS_EN is defined.
module tb_cache_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata;
    logic         cpu_read, cpu_write, cpu_ready, mem_read, mem_write;
    logic [127:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    int total = 0;
    int pass  = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Memory: words 0x10..0x13 hold A0..A3, everything else 0x1000_0000 + address.
    logic [31:0] mem [0:1023];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= (i >= 16 && i <= 19) ? 32'(32'hA0 + i - 16) : 32'(32'h1000_0000 + i);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 4; k++)
            mem_rdata[k*32 +: 32] = mem[int'({mem_addr[9:2], 2'b00}) + k];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h7;
        tick; tick; tick; #2;
        total++;
        if ({cpu_ready, mem_read, mem_write} !== 3'b000 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || cpu_rdata !== 32'h0)
            $display("FAIL reset_outputs got rdy/rd/wr=%b addr=%h wdata=%h rdata=%h exp all zero",
                     {cpu_ready, mem_read, mem_write}, mem_addr, mem_wdata, cpu_rdata);
        else pass++;
`ifdef CACHE_STATS_EN
        total++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0)
            $display("FAIL reset_stats got hit=%0d miss=%0d exp 0/0", hit_count, miss_count);
        else pass++;
`endif
        rst = 1'b1;
        cpu_read = 1'b0;
        #1;
        total++;
        if ({cpu_ready, mem_read, mem_write} !== 3'b000 || mem_addr !== 32'h10 || mem_wdata !== 32'h7)
            $display("FAIL idle_passthru got rdy/rd/wr=%b addr=%h wdata=%h exp 000 10 7",
                     {cpu_ready, mem_read, mem_write}, mem_addr, mem_wdata);
        else pass++;
    endtask

    task automatic test_read_miss;
        tick; req(1'b1, 1'b0, 32'h10, 32'h0);
        total++;
        if ({cpu_ready, mem_read} !== 2'b00)
            $display("FAIL miss_detect got rdy/rd=%b exp 00", {cpu_ready, mem_read});
        else pass++;
        for (int i = 0; i < 4; i++) begin
            tick; #2;
            total++;
            if ({cpu_ready, mem_read, mem_write} !== 3'b010 || mem_addr !== 32'h10)
                $display("FAIL fill_cycle%0d got rdy/rd/wr=%b addr=%h exp 010 10",
                         i, {cpu_ready, mem_read, mem_write}, mem_addr);
            else pass++;
        end
        tick; #2;
        total++;
        if ({cpu_ready, mem_read} !== 2'b10 || cpu_rdata !== 32'hA0)
            $display("FAIL miss_replay got rdy/rd=%b rdata=%h exp 10 A0", {cpu_ready, mem_read}, cpu_rdata);
        else pass++;
    endtask

    task automatic test_read_hit;
        tick; req(1'b1, 1'b0, 32'h13, 32'h0);
        total++;
        if ({cpu_ready, mem_read} !== 2'b10 || cpu_rdata !== 32'hA3)
            $display("FAIL hit_0x13 got rdy/rd=%b rdata=%h exp 10 A3", {cpu_ready, mem_read}, cpu_rdata);
        else pass++;
        tick; req(1'b0, 1'b0, 32'h13, 32'h0);
        total++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0)
            $display("FAIL idle_rdata got rdy=%b rdata=%h exp 0 0", cpu_ready, cpu_rdata);
        else pass++;
`ifdef CACHE_STATS_EN
        total++;
        if (hit_count !== 16'd1 || miss_count !== 16'd1)
            $display("FAIL stats_after_hit got hit=%0d miss=%0d exp 1/1", hit_count, miss_count);
        else pass++;
`endif
    endtask

    task automatic test_write_hit;
        tick; req(1'b0, 1'b1, 32'h11, 32'hDEAD);
        total++;
        if ({cpu_ready, mem_write} !== 2'b00)
            $display("FAIL wr_detect got rdy/wr=%b exp 00", {cpu_ready, mem_write});
        else pass++;
        tick; #2;
        total++;
        if ({cpu_ready, mem_read, mem_write} !== 3'b101 || mem_addr !== 32'h11 || mem_wdata !== 32'hDEAD)
            $display("FAIL wr_hit_strobe got rdy/rd/wr=%b addr=%h wdata=%h exp 101 11 DEAD",
                     {cpu_ready, mem_read, mem_write}, mem_addr, mem_wdata);
        else pass++;
        tick; req(1'b1, 1'b0, 32'h11, 32'h0);
        total++;
        if ({cpu_ready, mem_read, mem_write} !== 3'b100 || cpu_rdata !== 32'hDEAD)
            $display("FAIL rd_after_wr got rdy/rd/wr=%b rdata=%h exp 100 DEAD",
                     {cpu_ready, mem_read, mem_write}, cpu_rdata);
        else pass++;
    endtask

    task automatic test_write_miss;
        tick; req(1'b0, 1'b1, 32'h200, 32'h5);
        tick; #2;
        total++;
        if ({cpu_ready, mem_read, mem_write} !== 3'b101 || mem_addr !== 32'h200)
            $display("FAIL wr_miss_strobe got rdy/rd/wr=%b addr=%h exp 101 200",
                     {cpu_ready, mem_read, mem_write}, mem_addr);
        else pass++;
        tick; req(1'b1, 1'b0, 32'h200, 32'h0);
        total++;
        if ({cpu_ready, mem_read} !== 2'b00)
            $display("FAIL no_allocate got rdy/rd=%b exp 00", {cpu_ready, mem_read});
        else pass++;
        for (int i = 0; i < 4; i++) begin
            tick; #2;
            total++;
            if (mem_read !== 1'b1 || mem_addr !== 32'h200)
                $display("FAIL fill200_cycle%0d got rd=%b addr=%h exp 1 200", i, mem_read, mem_addr);
            else pass++;
        end
        tick; #2;
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h5)
            $display("FAIL rd_0x200 got rdy=%b rdata=%h exp 1 5", cpu_ready, cpu_rdata);
        else pass++;
    endtask

    task automatic test_reset_fill;
        tick; req(1'b1, 1'b0, 32'h14, 32'h0);
        tick; #2;
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h14)
            $display("FAIL fill14_start got rd=%b addr=%h exp 1 14", mem_read, mem_addr);
        else pass++;
        tick; rst = 1'b0; #2;
        total++;
        if ({cpu_ready, mem_read} !== 2'b00)
            $display("FAIL rst_in_fill got rdy/rd=%b exp 00", {cpu_ready, mem_read});
        else pass++;
        tick; rst = 1'b1; req(1'b1, 1'b0, 32'h10, 32'h0);
        total++;
        if ({cpu_ready, mem_read} !== 2'b00)
            $display("FAIL after_rst got rdy/rd=%b exp 00", {cpu_ready, mem_read});
        else pass++;
        tick; #2;
        total++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h10)
            $display("FAIL refill_0x10 got rd=%b addr=%h exp 1 10", mem_read, mem_addr);
        else pass++;
        tick; tick; tick; tick; #2;
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA0)
            $display("FAIL refill_data got rdy=%b rdata=%h exp 1 A0", cpu_ready, cpu_rdata);
        else pass++;
    endtask

    task automatic test_conflict;
        logic [31:0] addrs [2];
        logic [31:0] exps  [2];
        addrs[0] = 32'h110; exps[0] = 32'h1000_0110;
        addrs[1] = 32'h10;  exps[1] = 32'hA0;
        for (int j = 0; j < 2; j++) begin
            tick; req(1'b1, 1'b0, addrs[j], 32'h0);
            total++;
            if (cpu_ready !== 1'b0)
                $display("FAIL conflict_miss%0d got rdy=%b exp 0", j, cpu_ready);
            else pass++;
            tick; tick; tick; tick; #2;
            total++;
            if (mem_read !== 1'b1 || mem_addr !== addrs[j])
                $display("FAIL conflict_fill%0d got rd=%b addr=%h exp 1 %h", j, mem_read, mem_addr, addrs[j]);
            else pass++;
            tick; #2;
            total++;
            if (cpu_ready !== 1'b1 || cpu_rdata !== exps[j])
                $display("FAIL conflict_data%0d got rdy=%b rdata=%h exp 1 %h", j, cpu_ready, cpu_rdata, exps[j]);
            else pass++;
        end
`ifdef CACHE_STATS_EN
        tick; req(1'b0, 1'b0, 32'h10, 32'h0);
        total++;
        if (hit_count !== 16'd0 || miss_count !== 16'd3)
            $display("FAIL stats_conflict got hit=%0d miss=%0d exp 0/3", hit_count, miss_count);
        else pass++;
`endif
    endtask

    task automatic test_back_to_back;
        // 0x12 is cached, so a read-only request would hit; write must win.
        tick; req(1'b1, 1'b1, 32'h12, 32'h55);
        total++;
        if ({cpu_ready, mem_read, mem_write} !== 3'b000)
            $display("FAIL rw_priority got rdy/rd/wr=%b exp 000", {cpu_ready, mem_read, mem_write});
        else pass++;
        tick; #2;
        total++;
        if ({cpu_ready, mem_write} !== 2'b11 || mem_wdata !== 32'h55)
            $display("FAIL rw_write got rdy/wr=%b wdata=%h exp 11 55", {cpu_ready, mem_write}, mem_wdata);
        else pass++;
        tick; req(1'b1, 1'b0, 32'h12, 32'h0);
        total++;
        if ({cpu_ready, mem_write} !== 2'b10 || cpu_rdata !== 32'h55)
            $display("FAIL b2b_read got rdy/wr=%b rdata=%h exp 10 55", {cpu_ready, mem_write}, cpu_rdata);
        else pass++;
        tick; req(1'b1, 1'b0, 32'h13, 32'h0);
        total++;
        if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA3)
            $display("FAIL b2b_read2 got rdy=%b rdata=%h exp 1 A3", cpu_ready, cpu_rdata);
        else pass++;
    endtask

    initial begin
        test_reset;
        test_read_miss;
        test_read_hit;
        test_write_hit;
        test_write_miss;
        test_reset_fill;
        test_conflict;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
